// File: rtl/pll_reset_sequencer.sv
// PLL power-up / loss-of-lock reset sequencer running on the reference clock.
// Optional `PLL_LOSS_CNT_EN adds the saturating lossCount output.
//
// state        | meaning
// ST_PLL_RST   | PLL held in reset (pllResetN=0) for RESET_CYCLES
// ST_WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT for lock
// ST_STABLE    | lock seen, must stay high for STABLE_CYCLES
// ST_RUN       | clock good, system reset released
// ST_FAILED    | retries exhausted, PLL held in reset until reset
module pll_reset_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int RETRY_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               isLocked,
  output logic               pllResetN,
  output logic               sysReset,
  output logic               clkReady,
  output logic               failed,
  output logic [RETRY_W-1:0] retries
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [7:0]         lossCount
`endif
);

  localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAILED    = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retries_nxt;
  logic               lock_meta, lock_sync;
  logic               pll_rst_n_nxt, sys_reset_nxt, clk_ready_nxt, failed_nxt;

  // isLocked comes from the PLL domain; two flops before any decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= isLocked;
      lock_sync <= lock_meta;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    retries_nxt = retries;
    case (state)
      ST_PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_sync) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_LAST) begin
          cnt_nxt = '0;
          if (retries == RETRY_MAX) begin
            state_nxt = ST_FAILED;
          end else begin
            state_nxt   = ST_PLL_RST;
            retries_nxt = retries + RETRY_W'(1);
          end
        end
      end
      ST_STABLE: begin
        if (!lock_sync) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt   = ST_RUN;
          cnt_nxt     = '0;
          retries_nxt = '0;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (!lock_sync) begin
          state_nxt = ST_PLL_RST;
        end
      end
      ST_FAILED: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = ST_PLL_RST;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs follow the state being entered so they change on the entry edge.
    pll_rst_n_nxt = !(state_nxt == ST_PLL_RST || state_nxt == ST_FAILED);
    sys_reset_nxt = (state_nxt != ST_RUN);
    clk_ready_nxt = (state_nxt == ST_RUN);
    failed_nxt    = (state_nxt == ST_FAILED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_PLL_RST;
      cnt       <= '0;
      retries   <= '0;
      pllResetN <= 1'b0;
      sysReset  <= 1'b1;
      clkReady  <= 1'b0;
      failed    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retries   <= retries_nxt;
      pllResetN <= pll_rst_n_nxt;
      sysReset  <= sys_reset_nxt;
      clkReady  <= clk_ready_nxt;
      failed    <= failed_nxt;
    end
  end

`ifdef PLL_LOSS_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lossCount <= 8'd0;
    end else if (state == ST_RUN && state_nxt == ST_PLL_RST && lossCount != 8'hFF) begin
      lossCount <= lossCount + 8'd1;
    end
  end
`endif

endmodule
